// File: rtl/mem_bus_responder.sv
// Single-outstanding memory responder: captures a line request, answers it LATENCY
// cycles later from an internal line store, then enforces a one-cycle gap.
module mem_bus_responder #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 128,
   parameter int MEM_LINES  = 4096,
   parameter int LATENCY    = 5,
   parameter int ID_WIDTH   = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_read,
   input  logic                  req_write,
   input  logic [ID_WIDTH-1:0]   req_id,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LINE_WIDTH-1:0] req_data,
   output logic                  resp_valid,
   output logic [ID_WIDTH-1:0]   resp_id,
   output logic [ADDR_WIDTH-1:0] resp_addr,
   output logic [LINE_WIDTH-1:0] resp_data,
   output logic                  busy
);

   localparam int OFF_W = $clog2(LINE_WIDTH / 8);
   localparam int IDX_W = $clog2(MEM_LINES);
   localparam logic [7:0] LOAD_VAL = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESPOND,
      S_GAP
   } state_t;

   state_t                r_state;
   logic [7:0]            r_count;
   logic [ID_WIDTH-1:0]   r_id;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LINE_WIDTH-1:0] r_wdata;
   logic                  r_is_write;
   logic [IDX_W-1:0]      r_idx;

   logic                  r_resp_valid;
   logic                  r_busy;
   logic [ID_WIDTH-1:0]   r_resp_id;
   logic [LINE_WIDTH-1:0] r_rd_data;

   logic [LINE_WIDTH-1:0] r_mem [MEM_LINES];

   logic                  w_req;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_unused_addr;

   assign w_req         = req_read | req_write;
   assign w_idx         = req_addr[OFF_W +: IDX_W];
   assign w_unused_addr = ^{req_addr[ADDR_WIDTH-1:OFF_W+IDX_W], req_addr[OFF_W-1:0]};

   // Outputs are registered from the current state, so the response strobe
   // appears in the cycle after RESPOND, LATENCY cycles after capture.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_count      <= '0;
         r_resp_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_resp_id    <= '0;
      end else begin
         r_resp_valid <= (r_state == S_RESPOND);
         r_busy       <= (r_state != S_IDLE);
         r_resp_id    <= (r_state == S_RESPOND) ? r_id : '0;
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_id       <= req_id;
                  r_addr     <= req_addr;
                  r_wdata    <= req_data;
                  r_is_write <= req_write;
                  r_idx      <= w_idx;
                  r_count    <= LOAD_VAL;
                  r_state    <= (LATENCY == 1) ? S_RESPOND : S_WAIT;
               end
            end
            S_WAIT: begin
               r_count <= r_count - 8'd1;
               if (r_count == 8'd1) begin
                  r_state <= S_RESPOND;
               end
            end
            S_RESPOND: r_state <= S_GAP;
            S_GAP:     r_state <= S_IDLE;
            default:   r_state <= S_IDLE;
         endcase
      end
   end

   // Read-first line store; a write commits only on a RESPOND edge not under reset.
   always_ff @(posedge clock) begin
      if (r_state == S_RESPOND && r_is_write && reset) begin
         r_mem[r_idx] <= r_wdata;
      end
      r_rd_data <= r_mem[r_idx];
   end

   assign resp_valid = r_resp_valid;
   assign resp_id    = r_resp_id;
   assign resp_addr  = r_addr;
   assign resp_data  = r_is_write ? r_wdata : r_rd_data;
   assign busy       = r_busy;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: a LATENCY=5 and a LATENCY=1 instance checked every
// cycle against a timeline model, plus directed literal checks.
module tb_mem_bus_responder;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic         rstn_i  [2];
   logic         rd_i    [2];
   logic         wr_i    [2];
   logic [0:0]   id_i    [2];
   logic [31:0]  addr_i  [2];
   logic [127:0] data_i  [2];
   logic         rv_o    [2];
   logic         busy_o  [2];
   logic [0:0]   rid_o   [2];
   logic [31:0]  raddr_o [2];
   logic [127:0] rdata_o [2];

   mem_bus_responder #(.LATENCY(5)) dut0 (
      .clock(clk), .reset(rstn_i[0]), .req_read(rd_i[0]), .req_write(wr_i[0]),
      .req_id(id_i[0]), .req_addr(addr_i[0]), .req_data(data_i[0]),
      .resp_valid(rv_o[0]), .resp_id(rid_o[0]), .resp_addr(raddr_o[0]),
      .resp_data(rdata_o[0]), .busy(busy_o[0])
   );

   mem_bus_responder #(.LATENCY(1)) dut1 (
      .clock(clk), .reset(rstn_i[1]), .req_read(rd_i[1]), .req_write(wr_i[1]),
      .req_id(id_i[1]), .req_addr(addr_i[1]), .req_data(data_i[1]),
      .resp_valid(rv_o[1]), .resp_id(rid_o[1]), .resp_addr(raddr_o[1]),
      .resp_data(rdata_o[1]), .busy(busy_o[1])
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int pulses [2];

   // Timeline model: a request accepted at edge a answers in cycle a+L, keeps busy
   // over cycles a+1..a+L+1, and the next request can be taken at edge a+L+2.
   logic [127:0] mmem [int];
   bit           pend   [2];
   int           acc    [2];
   logic [0:0]   pid    [2];
   logic [31:0]  paddr  [2];
   logic [127:0] pdata  [2];
   bit           pwr    [2];
   int           pkey   [2];
   bit           e_rv   [2];
   bit           e_busy [2];
   logic [0:0]   e_id   [2];
   logic [31:0]  e_addr [2];
   logic [127:0] e_data [2];
   bit           e_known[2];

   task automatic chk(input string name, input int u, input logic [127:0] got,
                      input logic [127:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s dut%0d cyc %0d: got %h want %h", name, u, cyc, got, want);
      end
   endtask

   task automatic model_edge(input int u);
      int lat;
      lat = (u == 0) ? 5 : 1;
      e_rv[u]   = 1'b0;
      e_busy[u] = 1'b0;
      e_id[u]   = '0;
      if (!rstn_i[u]) begin
         pend[u] = 1'b0;
      end else if (pend[u]) begin
         e_busy[u] = 1'b1;
         if (cyc == acc[u] + lat) begin
            e_rv[u]   = 1'b1;
            e_id[u]   = pid[u];
            e_addr[u] = paddr[u];
            if (pwr[u]) begin
               e_data[u]  = pdata[u];
               e_known[u] = 1'b1;
               mmem[pkey[u]] = pdata[u];
            end else begin
               e_known[u] = mmem.exists(pkey[u]);
               e_data[u]  = e_known[u] ? mmem[pkey[u]] : '0;
            end
         end
         if (cyc == acc[u] + lat + 1) pend[u] = 1'b0;
      end else if (rd_i[u] || wr_i[u]) begin
         pend[u]  = 1'b1;
         acc[u]   = cyc;
         pid[u]   = id_i[u];
         paddr[u] = addr_i[u];
         pdata[u] = data_i[u];
         pwr[u]   = wr_i[u];
         pkey[u]  = u * 65536 + int'((addr_i[u] >> 4) % 32'd4096);
      end
   endtask

   initial begin
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      forever begin
         @(posedge clk);
         cyc++;
         model_edge(0);
         model_edge(1);
      end
   end

   initial begin
      pulses[0] = 0;
      pulses[1] = 0;
      forever begin
         @(negedge clk);
         if (cyc > 0) begin
            for (int u = 0; u < 2; u++) begin
               chk("resp_valid", u, 128'(rv_o[u]), 128'(e_rv[u]));
               chk("busy", u, 128'(busy_o[u]), 128'(e_busy[u]));
               chk("resp_id", u, 128'(rid_o[u]), 128'(e_id[u]));
               if (e_rv[u]) begin
                  chk("resp_addr", u, 128'(raddr_o[u]), 128'(e_addr[u]));
                  if (e_known[u]) chk("resp_data", u, rdata_o[u], e_data[u]);
               end
               if (rv_o[u] === 1'b1) pulses[u]++;
            end
         end
      end
   end

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic clear_req(input int u);
      rd_i[u]   = 1'b0;
      wr_i[u]   = 1'b0;
      id_i[u]   = '0;
      addr_i[u] = '0;
      data_i[u] = '0;
   endtask

   // Single-edge request; k is the edge that captures it.
   task automatic issue(input int u, input logic rd, input logic wr, input logic [0:0] id,
                        input logic [31:0] addr, input logic [127:0] data, output int k);
      @(negedge clk);
      rd_i[u]   = rd;
      wr_i[u]   = wr;
      id_i[u]   = id;
      addr_i[u] = addr;
      data_i[u] = data;
      k = cyc + 1;
      @(negedge clk);
      clear_req(u);
      $display("dut%0d req rd=%0b wr=%0b id=%0d addr=%h captured at edge %0d", u, rd, wr,
               id, addr, k);
   endtask

   task automatic lit_resp(input int u, input int k, input int lat, input logic [0:0] id,
                           input logic [31:0] addr, input logic [127:0] data);
      wait_cyc(k + lat - 1);
      chk("lit_rv_early", u, 128'(rv_o[u]), 128'd0);
      wait_cyc(k + lat);
      chk("lit_rv", u, 128'(rv_o[u]), 128'd1);
      chk("lit_id", u, 128'(rid_o[u]), 128'(id));
      chk("lit_addr", u, 128'(raddr_o[u]), 128'(addr));
      chk("lit_data", u, rdata_o[u], data);
      $display("dut%0d resp cyc %0d id=%0d addr=%h data=%h", u, cyc, rid_o[u], raddr_o[u],
               rdata_o[u]);
      wait_cyc(k + lat + 1);
      chk("lit_rv_late", u, 128'(rv_o[u]), 128'd0);
   endtask

   localparam logic [127:0] D_A5   = {16{8'hA5}};
   localparam logic [127:0] D_DB   = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
   localparam logic [127:0] D_X    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [127:0] D_OLD  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [127:0] D_Y    = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_0000;
   localparam logic [127:0] D_W    = 128'h5A5A_0F0F_C3C3_9696_1234_8765_ABCD_0011;

   initial begin
      int k;
      int s;
      int p0;
      for (int u = 0; u < 2; u++) begin
         rstn_i[u] = 1'b0;
         clear_req(u);
      end
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         chk("reset_rv", u, 128'(rv_o[u]), 128'd0);
         chk("reset_busy", u, 128'(busy_o[u]), 128'd0);
         chk("reset_id", u, 128'(rid_o[u]), 128'd0);
      end

      // Release with a write already held: first edge out of reset accepts it.
      rstn_i[0] = 1'b1;
      rstn_i[1] = 1'b1;
      wr_i[0]   = 1'b1;
      addr_i[0] = 32'h40;
      data_i[0] = D_A5;
      k = cyc + 1;
      for (int i = 0; i < 20 && rv_o[0] !== 1'b1; i++) @(negedge clk);
      chk("held_write_resp", 0, 128'(rv_o[0]), 128'd1);
      chk("held_write_latency", 0, 128'(cyc), 128'(k + 5));
      chk("held_write_echo", 0, rdata_o[0], D_A5);
      clear_req(0);
      repeat (2) @(negedge clk);

      issue(0, 1'b1, 1'b0, 1'b1, 32'h40, '0, k);
      wait_cyc(k);
      chk("busy_at_k", 0, 128'(busy_o[0]), 128'd0);
      wait_cyc(k + 1);
      chk("busy_k1", 0, 128'(busy_o[0]), 128'd1);
      lit_resp(0, k, 5, 1'b1, 32'h40, D_A5);
      chk("busy_k6", 0, 128'(busy_o[0]), 128'd1);
      wait_cyc(k + 7);
      chk("busy_k7", 0, 128'(busy_o[0]), 128'd0);

      // Address wrap: 0x10000 lands on line 0.
      issue(0, 1'b0, 1'b1, 1'b0, 32'h0, D_DB, k);
      lit_resp(0, k, 5, 1'b0, 32'h0, D_DB);
      issue(0, 1'b1, 1'b0, 1'b0, 32'h10000, '0, k);
      lit_resp(0, k, 5, 1'b0, 32'h10000, D_DB);

      // Read and write together is a write.
      issue(0, 1'b1, 1'b1, 1'b1, 32'h80, D_X, k);
      lit_resp(0, k, 5, 1'b1, 32'h80, D_X);
      issue(0, 1'b1, 1'b0, 1'b0, 32'h80, '0, k);
      lit_resp(0, k, 5, 1'b0, 32'h80, D_X);

      // Reset two cycles into a write aborts it and leaves the old line.
      issue(0, 1'b0, 1'b1, 1'b0, 32'h100, D_OLD, k);
      lit_resp(0, k, 5, 1'b0, 32'h100, D_OLD);
      issue(0, 1'b0, 1'b1, 1'b1, 32'h100, D_Y, k);
      p0 = pulses[0];
      wait_cyc(k + 1);
      rstn_i[0] = 1'b0;
      wait_cyc(k + 3);
      rstn_i[0] = 1'b1;
      wait_cyc(k + 10);
      chk("abort_no_resp", 0, 128'(pulses[0]), 128'(p0));
      $display("dut0 write aborted by reset, pulses %0d -> %0d", p0, pulses[0]);
      issue(0, 1'b1, 1'b0, 1'b0, 32'h100, '0, k);
      lit_resp(0, k, 5, 1'b0, 32'h100, D_OLD);

      // Continuous request: acceptances 7 edges apart.
      @(negedge clk);
      p0 = pulses[0];
      rd_i[0]   = 1'b1;
      addr_i[0] = 32'h40;
      s = cyc + 1;
      wait_cyc(s + 5);
      chk("cont_rv_1", 0, 128'(rv_o[0]), 128'd1);
      wait_cyc(s + 11);
      chk("cont_rv_gap", 0, 128'(rv_o[0]), 128'd0);
      wait_cyc(s + 12);
      chk("cont_rv_2", 0, 128'(rv_o[0]), 128'd1);
      wait_cyc(s + 13);
      chk("cont_rv_after", 0, 128'(rv_o[0]), 128'd0);
      wait_cyc(s + 20);
      clear_req(0);
      wait_cyc(s + 30);
      chk("cont_pulses", 0, 128'(pulses[0] - p0), 128'd3);
      $display("dut0 continuous read from edge %0d gave %0d responses", s, pulses[0] - p0);

      // LATENCY=1 instance: held write, answered next cycle, re-accepted 3 edges later.
      @(negedge clk);
      wr_i[1]   = 1'b1;
      addr_i[1] = 32'h200;
      data_i[1] = D_W;
      k = cyc + 1;
      wait_cyc(k);
      chk("l1_rv_k", 1, 128'(rv_o[1]), 128'd0);
      wait_cyc(k + 1);
      chk("l1_rv_k1", 1, 128'(rv_o[1]), 128'd1);
      chk("l1_data_k1", 1, rdata_o[1], D_W);
      wait_cyc(k + 2);
      chk("l1_rv_k2", 1, 128'(rv_o[1]), 128'd0);
      wait_cyc(k + 3);
      chk("l1_rv_k3", 1, 128'(rv_o[1]), 128'd0);
      clear_req(1);
      wait_cyc(k + 4);
      chk("l1_rv_k4", 1, 128'(rv_o[1]), 128'd1);
      wait_cyc(k + 5);
      chk("l1_rv_k5", 1, 128'(rv_o[1]), 128'd0);
      $display("dut1 held write from edge %0d answered at cycles %0d and %0d", k, k + 1, k + 4);
      issue(1, 1'b1, 1'b0, 1'b1, 32'h200, '0, k);
      lit_resp(1, k, 1, 1'b1, 32'h200, D_W);

      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte address width of the request address.
REQ-002 Parameter LINE_WIDTH, default 128, data width of one memory line, in bits (multiple of 8).
REQ-003 Parameter MEM_LINES, default 4096, number of lines stored (power of two).
REQ-004 Parameter LATENCY, default 5, cycles from request acceptance to response (legal range 1..255).
REQ-005 Parameter ID_WIDTH, default 1, width of the requester tag.
REQ-006 clock  input  1  single clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-low reset (low = reset asserted), sampled on the rising clock edge.
REQ-008 req_read  input  1  read request from the core bus master.
REQ-009 req_write  input  1  write request from the core bus master.
REQ-010 req_id  input  ID_WIDTH  requester tag (0 = dcache, 1 = icache).
REQ-011 req_addr  input  ADDR_WIDTH  byte address of the line.
REQ-012 req_data  input  LINE_WIDTH  write data, full line.
REQ-013 resp_valid  output  1  one-cycle response strobe.
REQ-014 resp_id  output  ID_WIDTH  tag of the request being answered.
REQ-015 resp_addr  output  ADDR_WIDTH  address of the request being answered.
REQ-016 resp_data  output  LINE_WIDTH  read data, or echoed write data.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM has four states: IDLE, WAIT, RESPOND and GAP; at most one request is outstanding.
REQ-019 IDLE: a rising edge with req_read or req_write high captures id, addr, data and op, loads the counter with LATENCY-1, and goes to WAIT (to RESPOND if LATENCY=1).
REQ-020 WAIT: the counter decrements each cycle; at count 0 the FSM goes to RESPOND on the next edge; request inputs are ignored.
REQ-021 RESPOND: resp_valid=1 for exactly one cycle; this cycle begins exactly LATENCY clock cycles after the capturing edge; the FSM then goes to GAP.
REQ-022 GAP: lasts one cycle, ignores requests (gives the master time to drop its still-asserted request), and then returns to IDLE.
REQ-023 The minimum spacing between acceptances is LATENCY+2 cycles.
REQ-024 Line index = req_addr[log2(LINE_WIDTH/8) +: log2(MEM_LINES)].
  - Low offset bits and upper bits are ignored.
  - Addresses beyond MEM_LINES lines wrap by truncation.
REQ-025 Read: resp_data equals the stored line at the index, as of the RESPOND cycle.
REQ-026 Write: the line is written on the edge that ends RESPOND, and resp_data equals the captured write data.
REQ-027 If req_read and req_write are both high at capture, the request is treated as a write.
REQ-028 resp_id and resp_addr equal the captured values during RESPOND; resp_data and resp_addr are don't-care while resp_valid=0; resp_id is held at 0 while resp_valid=0 (REQ-030).
REQ-029 Changes to the request inputs after capture have no effect on the transaction in flight.

Reset
REQ-030 While reset=0, on every edge the block enters IDLE with resp_valid=0, busy=0, resp_id=0 and counter=0.
REQ-031 Reset asserted in WAIT or RESPOND aborts the transaction: no response is issued and the pending write is not committed.
REQ-032 Memory contents are not cleared by reset.
REQ-033 A request held high on the first edge after reset is released (reset=1) is accepted.

Verification
REQ-034 Read, LATENCY=5: hold req_write=1, id=0, addr=0x40, data=0xA5..A5 until resp_valid; then hold req_read=1, id=1, addr=0x40 at edge k -> resp_valid high only in the cycle starting at edge k+5, with resp_id=1, resp_addr=0x40, resp_data=0xA5..A5, busy high from k+1 to k+6.
REQ-035 Wrap: write line 0xDEAD..BEEF to addr 0x0; read addr MEM_LINES*16 (0x10000) -> resp_data=0xDEAD..BEEF.
REQ-036 Read and write both high at addr 0x80 with data X -> response echoes X; a subsequent read of 0x80 returns X.
REQ-037 Request held high continuously -> acceptances exactly LATENCY+2 edges apart, one resp_valid pulse per acceptance, and no request is accepted during GAP.
REQ-038 Write to 0x100 with data Y, reset=0 asserted 2 cycles after capture -> no resp_valid; after release, a read of 0x100 returns the old contents, not Y.
REQ-039 LATENCY=1: request at edge k -> resp_valid in the cycle after edge k+1; a request held high is next accepted at edge k+3.
